// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the byte-serial IF/MEM RAM arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IF_RD,
        MEM_RD,
        MEM_WR
    } arb_state_e;

    localparam logic [1:0]  LEN_B    = 2'd0;
    localparam logic [1:0]  LEN_H    = 2'd1;
    localparam logic [1:0]  LEN_W    = 2'd3;
    localparam logic [2:0]  IF_BYTES = 3'd4;
    localparam logic [31:0] Zero     = '0;

    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_B:   return 3'd1;
            LEN_H:   return 3'd2;
            LEN_W:   return 3'd4;
            default: return 3'd3;
        endcase
    endfunction

    function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] lane);
        return w[8*lane +: 8];
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Pipeline-side and RAM-side signals of the arbiter; slave = arbiter view.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [31:0]       if_inst;
    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_len;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_done;
    logic [31:0]       mem_rdata;
    logic              jump_flag;
    logic [7:0]        ram_din;
    logic [7:0]        ram_dout;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;
    logic              stall_req_if;
    logic              stall_req_mem;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata,
               jump_flag, ram_din,
        output if_done, if_inst, mem_done, mem_rdata, ram_dout, ram_a, ram_wr,
               stall_req_if, stall_req_mem
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata,
               jump_flag, ram_din,
        input  if_done, if_inst, mem_done, mem_rdata, ram_dout, ram_a, ram_wr,
               stall_req_if, stall_req_mem
    );

endinterface

// File: rtl/mem_arbiter.sv
// Byte-serial arbiter sharing one 8-bit RAM port between fetch and load/store.
// Define MEM_ARB_IO_STALL_EN to add io_buffer_full back-pressure on IO-region stores.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned IO_SEL_BIT = 17
) (
    input  logic clk,
    input  logic rst,
`ifdef MEM_ARB_IO_STALL_EN
    input  logic io_buffer_full,
`endif
    mem_arbiter_if.slave bus
);

    arb_state_e        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        n_q, n_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       buf_q, buf_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;
    logic [31:0]       if_inst_q, if_inst_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic              ram_wr_q, ram_wr_d;
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic [7:0]        ram_dout_q, ram_dout_d;

    logic [2:0]        cnt_inc;
    logic [1:0]        lane_rd;
    logic [1:0]        lane_wr;
    logic              io_full;
    logic              io_region;
    logic              io_stall;

    assign cnt_inc = cnt_q + 3'd1;
    assign lane_rd = cnt_q[1:0] - 2'd1;
    assign lane_wr = cnt_q[1:0] + 2'd1;

`ifdef MEM_ARB_IO_STALL_EN
    assign io_full = io_buffer_full;
`else
    assign io_full = 1'b0;
`endif
    assign io_region = (ram_a_q[IO_SEL_BIT -: 2] == 2'b11);
    // Gates the already-registered strobe so a full IO buffer blocks the byte this cycle.
    assign io_stall  = (state_q == MEM_WR) && io_full && io_region;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_inst_d   = if_inst_q;
        mem_rdata_d = mem_rdata_q;
        ram_wr_d    = ram_wr_q;
        ram_a_d     = ram_a_q;
        ram_dout_d  = ram_dout_q;

        case (state_q)
            IDLE: begin
                ram_wr_d = 1'b0;
                // A port still showing done is the request just served; skip it once.
                if (bus.mem_req && !mem_done_q) begin
                    base_d  = bus.mem_addr;
                    n_d     = len_bytes(bus.mem_len);
                    wdata_d = bus.mem_wdata;
                    cnt_d   = '0;
                    buf_d   = Zero;
                    ram_a_d = bus.mem_addr;
                    if (bus.mem_we) begin
                        state_d    = MEM_WR;
                        ram_wr_d   = 1'b1;
                        ram_dout_d = bus.mem_wdata[7:0];
                    end else begin
                        state_d = MEM_RD;
                    end
                end else if (bus.if_req && !if_done_q) begin
                    base_d  = bus.if_addr;
                    n_d     = IF_BYTES;
                    cnt_d   = '0;
                    buf_d   = Zero;
                    ram_a_d = bus.if_addr;
                    state_d = IF_RD;
                end
            end

            IF_RD, MEM_RD: begin
                if (state_q == IF_RD && bus.jump_flag) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    if (cnt_q != 3'd0) begin
                        buf_d[8*lane_rd +: 8] = bus.ram_din;
                    end
                    if (cnt_q == n_q) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        if (state_q == IF_RD) begin
                            if_done_d = 1'b1;
                            if_inst_d = buf_d;
                        end else begin
                            mem_done_d  = 1'b1;
                            mem_rdata_d = buf_d;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc < n_q) begin
                            ram_a_d = base_q + ADDR_W'(cnt_inc);
                        end
                    end
                end
            end

            MEM_WR: begin
                if (!io_stall) begin
                    if (cnt_q == n_q - 3'd1) begin
                        state_d    = IDLE;
                        cnt_d      = '0;
                        ram_wr_d   = 1'b0;
                        mem_done_d = 1'b1;
                    end else begin
                        cnt_d      = cnt_inc;
                        ram_wr_d   = 1'b1;
                        ram_a_d    = base_q + ADDR_W'(cnt_inc);
                        ram_dout_d = lane_byte(wdata_q, lane_wr);
                    end
                end
            end

            default: begin
                state_d  = IDLE;
                cnt_d    = '0;
                ram_wr_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            base_q      <= '0;
            wdata_q     <= '0;
            buf_q       <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_inst_q   <= Zero;
            mem_rdata_q <= Zero;
            ram_wr_q    <= 1'b0;
            ram_a_q     <= '0;
            ram_dout_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_inst_q   <= if_inst_d;
            mem_rdata_q <= mem_rdata_d;
            ram_wr_q    <= ram_wr_d;
            ram_a_q     <= ram_a_d;
            ram_dout_q  <= ram_dout_d;
        end
    end

    assign bus.if_done       = if_done_q;
    assign bus.if_inst       = if_inst_q;
    assign bus.mem_done      = mem_done_q;
    assign bus.mem_rdata     = mem_rdata_q;
    assign bus.ram_wr        = ram_wr_q && !io_stall;
    assign bus.ram_a         = ram_a_q;
    assign bus.ram_dout      = ram_dout_q;
    assign bus.stall_req_if  = bus.if_req && !if_done_q;
    assign bus.stall_req_mem = bus.mem_req && !mem_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a byte RAM model and write log.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

`ifdef MEM_ARB_IO_STALL_EN
    logic io_buffer_full = 1'b0;
`endif

    mem_arbiter_if #(.ADDR_W(32)) bus();

    mem_arbiter #(.ADDR_W(32), .IO_SEL_BIT(17)) dut (
        .clk(clk),
        .rst(rst),
`ifdef MEM_ARB_IO_STALL_EN
        .io_buffer_full(io_buffer_full),
`endif
        .bus(bus)
    );

    bit   [7:0]  ram [0:262143];
    logic [31:0] wlog_a[$];
    logic [7:0]  wlog_d[$];
    int errors = 0;
    int checks = 0;

    always @(posedge clk) begin
        bus.ram_din <= ram[bus.ram_a[17:0]];
        if (bus.ram_wr === 1'b1) begin
            wlog_a.push_back(bus.ram_a);
            wlog_d.push_back(bus.ram_dout);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick();
        tick();
        checks++;
        if ({bus.if_done, bus.mem_done, bus.ram_wr} !== 3'b000) begin
            errors++; $display("FAIL reset_strobes: got %b required 000", {bus.if_done, bus.mem_done, bus.ram_wr});
        end
        checks++;
        if ({bus.if_inst, bus.mem_rdata} !== 64'h0) begin
            errors++; $display("FAIL reset_data: got %h/%h required 0/0", bus.if_inst, bus.mem_rdata);
        end
        checks++;
        if ({bus.ram_a, bus.ram_dout} !== 40'h0) begin
            errors++; $display("FAIL reset_ram: got a=%h d=%h required 0/0", bus.ram_a, bus.ram_dout);
        end
        rst = 1'b0;
    endtask

    task automatic test_word_fetch;
        bus.if_addr = 32'h100;
        bus.if_req  = 1'b1;
        #1;
        checks++;
        if (bus.stall_req_if !== 1'b1) begin
            errors++; $display("FAIL fetch_stall_c0: got %b required 1", bus.stall_req_if);
        end
        for (int c = 1; c <= 5; c++) begin
            tick();
            checks++;
            if (bus.if_done !== 1'b0 || bus.stall_req_if !== 1'b1) begin
                errors++; $display("FAIL fetch_wait c%0d: done=%b stall=%b required 0/1", c, bus.if_done, bus.stall_req_if);
            end
        end
        tick();
        checks++;
        if (bus.if_done !== 1'b1 || bus.if_inst !== 32'h00100513 || bus.stall_req_if !== 1'b0) begin
            errors++; $display("FAIL fetch_done: done=%b inst=%h stall=%b required 1/00100513/0",
                               bus.if_done, bus.if_inst, bus.stall_req_if);
        end
        bus.if_req = 1'b0;
        tick();
        checks++;
        if (bus.if_done !== 1'b0 || bus.if_inst !== 32'h00100513) begin
            errors++; $display("FAIL fetch_hold: done=%b inst=%h required 0/00100513", bus.if_done, bus.if_inst);
        end
    endtask

    task automatic byte_load_a5(input string tag);
        bus.mem_we   = 1'b0;
        bus.mem_len  = LEN_B;
        bus.mem_addr = 32'h200;
        bus.mem_req  = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            tick();
            checks++;
            if (bus.mem_done !== 1'b0 || bus.stall_req_mem !== 1'b1) begin
                errors++; $display("FAIL %s_wait c%0d: done=%b stall=%b required 0/1", tag, c, bus.mem_done, bus.stall_req_mem);
            end
        end
        tick();
        checks++;
        if (bus.mem_done !== 1'b1 || bus.mem_rdata !== 32'h000000A5) begin
            errors++; $display("FAIL %s_done: done=%b rdata=%h required 1/000000a5", tag, bus.mem_done, bus.mem_rdata);
        end
        bus.mem_req = 1'b0;
        tick();
    endtask

    task automatic test_byte_load;
        byte_load_a5("byte_load");
    endtask

    task automatic test_word_store;
        int base;
        logic [31:0] w;
        base = wlog_a.size();
        w = 32'hDEADBEEF;
        bus.mem_we    = 1'b1;
        bus.mem_len   = LEN_W;
        bus.mem_addr  = 32'h204;
        bus.mem_wdata = w;
        bus.mem_req   = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++;
            if (bus.ram_wr !== 1'b1 || bus.ram_a !== 32'h204 + 32'(c - 1) || bus.ram_dout !== w[8*(c-1) +: 8]
                || bus.mem_done !== 1'b0) begin
                errors++; $display("FAIL store_byte c%0d: wr=%b a=%h d=%h done=%b required 1/%h/%h/0",
                                   c, bus.ram_wr, bus.ram_a, bus.ram_dout, bus.mem_done,
                                   32'h204 + 32'(c - 1), w[8*(c-1) +: 8]);
            end
        end
        tick();
        checks++;
        if (bus.mem_done !== 1'b1 || bus.ram_wr !== 1'b0) begin
            errors++; $display("FAIL store_done: done=%b wr=%b required 1/0", bus.mem_done, bus.ram_wr);
        end
        bus.mem_req = 1'b0;
        tick();
        checks++;
        if (wlog_a.size() - base != 4) begin
            errors++; $display("FAIL store_count: got %0d required 4", wlog_a.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wlog_a[base+i] !== 32'h204 + 32'(i) || wlog_d[base+i] !== w[8*i +: 8]) begin
                    errors++; $display("FAIL store_log%0d: got %h=%h required %h=%h", i, wlog_a[base+i],
                                       wlog_d[base+i], 32'h204 + 32'(i), w[8*i +: 8]);
                end
            end
        end
    endtask

    task automatic test_conflict;
        int md_at;
        int id_at;
        md_at = 0;
        id_at = 0;
        bus.mem_we   = 1'b0;
        bus.mem_len  = LEN_H;
        bus.mem_addr = 32'h210;
        bus.mem_req  = 1'b1;
        bus.if_addr  = 32'h100;
        bus.if_req   = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (bus.mem_done === 1'b1 && md_at == 0) begin
                md_at = c;
                checks++;
                if (bus.mem_rdata !== 32'h00001234) begin
                    errors++; $display("FAIL conflict_rdata: got %h required 00001234", bus.mem_rdata);
                end
                bus.mem_req = 1'b0;
            end
            if (bus.if_done === 1'b1 && id_at == 0) begin
                id_at = c;
                checks++;
                if (bus.if_inst !== 32'h00100513) begin
                    errors++; $display("FAIL conflict_inst: got %h required 00100513", bus.if_inst);
                end
                bus.if_req = 1'b0;
            end
            if (c == 4) begin
                checks++;
                if (bus.ram_a !== 32'h211) begin
                    errors++; $display("FAIL conflict_turnaround_a: got %h required 00000211", bus.ram_a);
                end
            end
            if (c == 5) begin
                checks++;
                if (bus.ram_a !== 32'h100) begin
                    errors++; $display("FAIL conflict_if_start_a: got %h required 00000100", bus.ram_a);
                end
            end
        end
        checks++;
        if (md_at != 4) begin
            errors++; $display("FAIL conflict_mem_latency: got %0d required 4", md_at);
        end
        checks++;
        if (id_at != 10) begin
            errors++; $display("FAIL conflict_if_latency: got %0d required 10", id_at);
        end
        bus.mem_req = 1'b0;
        bus.if_req  = 1'b0;
        tick();
    endtask

    task automatic test_abort;
        bus.if_addr = 32'h100;
        bus.if_req  = 1'b1;
        for (int c = 1; c <= 3; c++) tick();
        checks++;
        if (bus.ram_a !== 32'h102) begin
            errors++; $display("FAIL abort_cnt2_a: got %h required 00000102", bus.ram_a);
        end
        bus.jump_flag = 1'b1;
        bus.if_addr   = 32'h300;
        tick();
        bus.jump_flag = 1'b0;
        for (int c = 4; c <= 9; c++) begin
            if (c > 4) tick();
            checks++;
            if (bus.if_done !== 1'b0 || bus.if_inst !== 32'h00100513) begin
                errors++; $display("FAIL abort_wait c%0d: done=%b inst=%h required 0/00100513", c, bus.if_done, bus.if_inst);
            end
        end
        tick();
        checks++;
        if (bus.if_done !== 1'b1 || bus.if_inst !== 32'h12345678) begin
            errors++; $display("FAIL abort_refetch: done=%b inst=%h required 1/12345678", bus.if_done, bus.if_inst);
        end
        bus.if_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_store;
        int base;
        base = wlog_a.size();
        bus.mem_we    = 1'b1;
        bus.mem_len   = LEN_W;
        bus.mem_addr  = 32'h500;
        bus.mem_wdata = 32'h11223344;
        bus.mem_req   = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.ram_wr !== 1'b1 || bus.ram_a !== 32'h501) begin
            errors++; $display("FAIL midstore_pre: wr=%b a=%h required 1/00000501", bus.ram_wr, bus.ram_a);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.ram_wr !== 1'b0 || bus.ram_a !== 32'h0 || bus.ram_dout !== 8'h0) begin
            errors++; $display("FAIL midstore_ram: wr=%b a=%h d=%h required 0/0/0", bus.ram_wr, bus.ram_a, bus.ram_dout);
        end
        checks++;
        if (bus.if_inst !== 32'h0 || bus.mem_rdata !== 32'h0 || bus.mem_done !== 1'b0 || bus.if_done !== 1'b0) begin
            errors++; $display("FAIL midstore_outs: inst=%h rdata=%h done=%b%b required 0/0/00",
                               bus.if_inst, bus.mem_rdata, bus.if_done, bus.mem_done);
        end
        bus.mem_req = 1'b0;
        tick();
        rst = 1'b0;
        checks++;
        if (wlog_a.size() - base != 1) begin
            errors++; $display("FAIL midstore_count: got %0d required 1", wlog_a.size() - base);
        end else begin
            checks++;
            if (wlog_a[base] !== 32'h500 || wlog_d[base] !== 8'h44) begin
                errors++; $display("FAIL midstore_log: got %h=%h required 00000500=44", wlog_a[base], wlog_d[base]);
            end
        end
        byte_load_a5("post_reset_load");
    endtask

`ifdef MEM_ARB_IO_STALL_EN
    task automatic test_io_stall;
        int base;
        base = wlog_a.size();
        io_buffer_full = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_len   = LEN_B;
        bus.mem_addr  = 32'h30000;
        bus.mem_wdata = 32'h0000005A;
        bus.mem_req   = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++;
            if (bus.ram_wr !== 1'b0 || bus.mem_done !== 1'b0) begin
                errors++; $display("FAIL io_hold c%0d: wr=%b done=%b required 0/0", c, bus.ram_wr, bus.mem_done);
            end
        end
        tick();
        io_buffer_full = 1'b0;
        #1;
        checks++;
        if (bus.ram_wr !== 1'b1 || bus.ram_a !== 32'h30000 || bus.ram_dout !== 8'h5A) begin
            errors++; $display("FAIL io_issue: wr=%b a=%h d=%h required 1/00030000/5a", bus.ram_wr, bus.ram_a, bus.ram_dout);
        end
        tick();
        checks++;
        if (bus.mem_done !== 1'b1) begin
            errors++; $display("FAIL io_done: got %b required 1", bus.mem_done);
        end
        bus.mem_req = 1'b0;
        tick();
        checks++;
        if (wlog_a.size() - base != 1) begin
            errors++; $display("FAIL io_count: got %0d required 1", wlog_a.size() - base);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_len   = LEN_B;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.jump_flag = 1'b0;
        ram['h100] = 8'h13; ram['h101] = 8'h05; ram['h102] = 8'h10; ram['h103] = 8'h00;
        ram['h200] = 8'hA5; ram['h201] = 8'h77;
        ram['h210] = 8'h34; ram['h211] = 8'h12;
        ram['h300] = 8'h78; ram['h301] = 8'h56; ram['h302] = 8'h34; ram['h303] = 8'h12;

        test_reset();
        test_word_fetch();
        test_byte_load();
        test_word_store();
        test_conflict();
        test_abort();
        test_reset_mid_store();
`ifdef MEM_ARB_IO_STALL_EN
        test_io_stall();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
